// File: rtl/cdb_broadcast_arbiter_pkg.sv
// Shared definitions for the CDB broadcast arbiter: FSM encoding, default
// sizes and the fixed requester slot assignment.
package cdb_broadcast_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BCAST = 1'b1
  } cdb_state_e;

  localparam int unsigned N_REQ_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned TAG_W_DEF  = 5;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_MUL = 1;
  localparam int unsigned REQ_LSU = 2;
  localparam int unsigned REQ_BRU = 3;

  // Broadcast counter holds BCAST_LEN-1, and BCAST_LEN never exceeds 8.
  localparam int unsigned CNT_W = 3;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_broadcast_arbiter_rr_priority_picker.sv
// Round-robin picker: returns the first asserted request at or after ptr_i,
// wrapping modulo N.
module rr_priority_picker
  import cdb_broadcast_arbiter_pkg::*;
#(
  parameter int unsigned N     = N_REQ_DEF,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] pos_s;

  // Scan from the pointer; ptr_i < N so one conditional subtract wraps the sum.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum_s = '0;
    pos_s = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum_s = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum_s >= (IDX_W+1)'(N)) begin
        sum_s = sum_s - (IDX_W+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      pos_s = sum_s[IDX_W-1:0];
      if (!any_o && req_i[pos_s]) begin
        any_o        = 1'b1;
        gnt_o[pos_s] = 1'b1;
        idx_o        = pos_s;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// Common data bus arbiter: grants one result requester round-robin and holds
// its tag/data on the CDB for BCAST_LEN cycles, allowing back-to-back grants.
module cdb_broadcast_arbiter
  import cdb_broadcast_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ     = N_REQ_DEF,
  parameter  int unsigned DATA_W    = DATA_W_DEF,
  parameter  int unsigned TAG_W     = TAG_W_DEF,
  parameter  int unsigned BCAST_LEN = 2,
  localparam int unsigned IDX_W     = idx_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    allowBroadcast,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [IDX_W-1:0]        cdb_src,
  output logic                    broadcastDataAvailable,
  output logic                    ongoingBroadcast
);

  cdb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  src_q, src_d;

  logic [TAG_W-1:0]  tag_arr_s  [N_REQ];
  logic [DATA_W-1:0] data_arr_s [N_REQ];
  logic [N_REQ-1:0]  pick_gnt_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic              pick_any_s;
  logic              grant_s;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign tag_arr_s[g]  = req_tag[g*TAG_W +: TAG_W];
    assign data_arr_s[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_priority_picker #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt_s),
    .idx_o (pick_idx_s),
    .any_o (pick_any_s)
  );

  // A new grant may issue from IDLE or in the final cycle of a broadcast.
  assign grant_s = pick_any_s && allowBroadcast && !flush &&
                   ((state_q == ST_IDLE) || (cnt_q == CNT_W'(0)));

  // Next-state and broadcast-register load logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    tag_d    = tag_q;
    data_d   = data_q;
    src_d    = src_q;
    if (grant_s) begin
      state_d  = ST_BCAST;
      cnt_d    = CNT_W'(BCAST_LEN - 1);
      tag_d    = tag_arr_s[pick_idx_s];
      data_d   = data_arr_s[pick_idx_s];
      src_d    = pick_idx_s;
      rr_ptr_d = (pick_idx_s == IDX_W'(N_REQ - 1)) ? IDX_W'(0) : pick_idx_s + IDX_W'(1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_BCAST: begin
          if (flush || (cnt_q == CNT_W'(0))) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_W'(0);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_W'(0);
        end
      endcase
    end
  end

  // State and broadcast registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_W'(0);
      rr_ptr_q <= IDX_W'(0);
      tag_q    <= TAG_W'(0);
      data_q   <= DATA_W'(0);
      src_q    <= IDX_W'(0);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      src_q    <= src_d;
    end
  end

  // Grant is combinational so a newly raised allowBroadcast wins the same cycle.
  assign req_ready              = pick_gnt_s & {N_REQ{grant_s & rst}};
  assign cdb_valid              = (state_q == ST_BCAST);
  assign cdb_tag                = tag_q;
  assign cdb_data               = data_q;
  assign cdb_src                = src_q;
  assign broadcastDataAvailable = |req_valid;
  assign ongoingBroadcast       = (state_q == ST_BCAST) && (cnt_q != CNT_W'(0));

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Scoreboard bench for cdb_broadcast_arbiter: stimulus queues expected
// grants, a negedge monitor checks grants and the CDB they produce.
module tb_cdb_broadcast_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        allow;
  logic [3:0]  rv;
  logic [19:0] tags;
  logic [127:0] datas;

  logic [3:0]  ready,  ready2;
  logic        cvalid, cvalid2;
  logic [4:0]  ctag,   ctag2;
  logic [31:0] cdata,  cdata2;
  logic [1:0]  csrc,   csrc2;
  logic        bda,    bda2;
  logic        ongo,   ongo2;

  always #5 clk = ~clk;

  cdb_broadcast_arbiter #(.BCAST_LEN(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .allowBroadcast(allow),
    .req_valid(rv), .req_tag(tags), .req_data(datas), .req_ready(ready),
    .cdb_valid(cvalid), .cdb_tag(ctag), .cdb_data(cdata), .cdb_src(csrc),
    .broadcastDataAvailable(bda), .ongoingBroadcast(ongo)
  );

  cdb_broadcast_arbiter #(.BCAST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .allowBroadcast(allow),
    .req_valid(rv), .req_tag(tags), .req_data(datas), .req_ready(ready2),
    .cdb_valid(cvalid2), .cdb_tag(ctag2), .cdb_data(cdata2), .cdb_src(csrc2),
    .broadcastDataAvailable(bda2), .ongoingBroadcast(ongo2)
  );

  typedef struct {
    int          src;
    logic [4:0]  tag;
    logic [31:0] data;
    int          len;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int src, input logic [4:0] tag, input logic [31:0] data, input int len);
    exp_t e;
    e.src = src; e.tag = tag; e.data = data; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [4:0] tag, input logic [31:0] data);
    tags[i*5 +: 5]    = tag;
    datas[i*32 +: 32] = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Main scoreboard monitor for the BCAST_LEN=2 instance.
  exp_t cur;
  int   rem = 0;
  always @(negedge clk) begin
    if (!rst) begin
      rem = 0;
    end else begin
      if (rem > 0) begin
        check("cdb_valid", cvalid, 1);
        check("cdb_tag", ctag, cur.tag);
        check("cdb_data", cdata, cur.data);
        check("cdb_src", csrc, cur.src);
        if (cur.len == 2) check("ongoing", ongo, (rem == 2) ? 1 : 0);
        rem--;
      end else begin
        check("cdb_idle", cvalid, 0);
      end
      if (ready != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", ready, 0);
        end else begin
          cur = exp_q.pop_front();
          check("req_ready", ready, 64'(4'b0001 << cur.src));
          rem = cur.len;
        end
      end
    end
  end

  // Monitor for the BCAST_LEN=1 instance during the all-valid phase.
  bit chk2 = 1'b0;
  int k2   = 0;
  always @(negedge clk) begin
    if (chk2) begin
      check("b1_ready", ready2, 64'(4'b0001 << (k2 % 4)));
      if (k2 > 0) begin
        check("b1_cdb_valid", cvalid2, 1);
        check("b1_cdb_src", csrc2, (k2 - 1) % 4);
        check("b1_cdb_tag", ctag2, 10 + ((k2 - 1) % 4));
        check("b1_ongoing", ongo2, 0);
      end
      k2++;
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0; allow = 1'b0; rv = 4'b0000;
    tags = '0; datas = '0;
    repeat (2) tick();
    check("rst_cdb_valid", cvalid, 0);
    check("rst_cdb_tag", ctag, 0);
    check("rst_cdb_data", cdata, 0);
    check("rst_cdb_src", csrc, 0);
    check("rst_ready", ready, 0);
    check("rst_ongoing", ongo, 0);
    rst = 1'b1;
    tick();

    // Fairness: all valid, expect 0,1,2,3,0,1,2,3 back to back.
    for (int i = 0; i < 4; i++) set_req(i, 5'(10 + i), 32'h0000_1000 + 32'(i));
    for (int i = 0; i < 8; i++) push(i % 4, 5'(10 + (i % 4)), 32'h0000_1000 + 32'(i % 4), 2);
    allow = 1'b1; rv = 4'b1111; chk2 = 1'b1; k2 = 0;
    repeat (15) tick();
    rv = 4'b0000; chk2 = 1'b0;
    check("fair_8_grants_no_gap", exp_q.size(), 0);
    repeat (3) tick();

    // Single request from requester 1.
    set_req(1, 5'd7, 32'h0000_DEAD);
    push(1, 5'd7, 32'h0000_DEAD, 2);
    rv = 4'b0010;
    #1 check("single_bda", bda, 1);
    tick();
    rv = 4'b0000;
    repeat (3) tick();

    // Blocking by allowBroadcast, then same-cycle grant.
    allow = 1'b0;
    set_req(3, 5'd21, 32'hCAFE_0003);
    rv = 4'b1000;
    #1 check("blk_ready", ready, 0);
    check("blk_bda", bda, 1);
    repeat (3) tick();
    check("blk_ready_held", ready, 0);
    push(3, 5'd21, 32'hCAFE_0003, 2);
    allow = 1'b1;
    #1 check("blk_same_cycle", ready, 4'b1000);
    tick();
    rv = 4'b0000;
    repeat (3) tick();

    // Flush in first BCAST cycle; rr_ptr must survive.
    set_req(2, 5'd18, 32'h0000_2222);
    push(2, 5'd18, 32'h0000_2222, 1);
    rv = 4'b0100;
    tick();
    rv = 4'b0000; flush = 1'b1;
    tick();
    set_req(0, 5'd16, 32'h0000_1111);
    set_req(3, 5'd19, 32'h0000_3333);
    rv = 4'b1001;
    #1 check("flush_blocks_ready", ready, 0);
    push(3, 5'd19, 32'h0000_3333, 2);
    flush = 1'b0;
    #1 check("flush_rr_kept", ready, 4'b1000);
    tick();
    rv = 4'b0000;
    repeat (3) tick();

    // Reset mid-broadcast, then rr_ptr restarts at 0.
    set_req(1, 5'd9, 32'h0000_9999);
    push(1, 5'd9, 32'h0000_9999, 1);
    rv = 4'b0010;
    tick();
    rv = 4'b0101;
    #1 rst = 1'b0;
    #1 check("mid_rst_cdb_valid", cvalid, 0);
    check("mid_rst_cdb_tag", ctag, 0);
    check("mid_rst_cdb_data", cdata, 0);
    check("mid_rst_cdb_src", csrc, 0);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_ongoing", ongo, 0);
    tick();
    check("mid_rst_hold_valid", cvalid, 0);
    push(0, 5'd16, 32'h0000_1111, 2);
    rst = 1'b1;
    #1 check("post_rst_winner", ready, 4'b0001);
    tick();
    rv = 4'b0000;
    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
